// File: rtl/serial_word_tx_if.sv
// Word-load handshake and serial output bundle for serial_word_tx.
// The master side supplies words; the slave side is the transmitter.
interface serial_word_tx_if #(
    parameter int WIDTH = 4
) ();
    logic             Load;
    logic [WIDTH-1:0] Din;
    logic             Ready;
    logic             D;
    logic             Busy;
    logic             Last;

    modport master (
        output Load,
        output Din,
        input  Ready,
        input  D,
        input  Busy,
        input  Last
    );

    modport slave (
        input  Load,
        input  Din,
        output Ready,
        output D,
        output Busy,
        output Last
    );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-in/serial-out word transmitter: one bit per clock on D, with
// zero-gap streaming when a new word is loaded during the final bit.
module serial_word_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic             Clk,
    input logic             Rst,
    serial_word_tx_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sr, sr_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             d_q, busy_q, last_q;
    logic             d_next, busy_next, last_next;
    logic             accept;

    // Bit that sits at the output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign bus.Ready = (state == IDLE) | last_q;
    assign accept    = bus.Load & bus.Ready;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    sr_next    = bus.Din;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (last_q) begin
                    if (accept) begin
                        sr_next  = bus.Din;
                        cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                        sr_next    = '0;
                        cnt_next   = '0;
                    end
                end else begin
                    sr_next  = shift_out(sr);
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                sr_next    = '0;
                cnt_next   = '0;
            end
        endcase

        // Outputs are registered from next-state values so D shows the first
        // bit directly after the accepting edge.
        busy_next = (state_next == SHIFT);
        last_next = busy_next && (cnt_next == CNT_LAST);
        d_next    = busy_next & out_bit(sr_next);
    end

    // NOTE: Rst is asynchronous, so it sits in the sensitivity list and a
    // partially sent word is dropped immediately, not at the next edge.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            d_q    <= 1'b0;
            busy_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            state  <= state_next;
            sr     <= sr_next;
            cnt    <= cnt_next;
            d_q    <= d_next;
            busy_q <= busy_next;
            last_q <= last_next;
        end
    end

    assign bus.D    = d_q;
    assign bus.Busy = busy_q;
    assign bus.Last = last_q;
endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-in/serial-out transmitter that feeds the single-bit `D` input of the 4-bit shift-register block. It accepts a `WIDTH`-bit word through a load/ready handshake and drives it onto `D` one bit per `Clk` cycle. A receiver that shifts `D` in on every rising edge holds the complete word `WIDTH` edges after the first bit appears. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 4: word length in bits; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit `WIDTH-1` is sent first; 0 = bit 0 is sent first.

- `Clk`, input, 1: single clock; all state updates on the rising edge.
- `Rst`, input, 1: reset; asynchronous, active-high.
- `Load`, input, 1: request to accept `Din`. Sampled only when `Ready` is 1.
- `Din`, input, `WIDTH`: parallel word, captured on an accepted `Load`.
- `Ready`, output, 1: transmitter can accept a word this cycle.
- `D`, output, 1: serial data, registered.
- `Busy`, output, 1: `D` is currently carrying a data bit.
- `Last`, output, 1: `D` is currently carrying the final bit of a word.

## Operation
- **State:** FSM with states IDLE and SHIFT, a `WIDTH`-bit shift register `sr`, and a bit counter `cnt` of width clog2(`WIDTH`).
- **Acceptance:** a word is accepted on a rising edge where `Load`=1 and `Ready`=1.
- **Ready:** combinational; `Ready = (state==IDLE) | Last`.
- **Load while not ready:** when `Ready`=0, `Load` and `Din` are ignored. No queuing and no error flag.
- **IDLE:**
  - `D`=0, `Busy`=0, `Last`=0.
  - On accept: load `sr` with `Din`, set `cnt`=0, go to SHIFT.
  - `D` presents the first bit (`Din[WIDTH-1]` if `MSB_FIRST`, else `Din[0]`) from that edge onward.
- **SHIFT:**
  - Each edge: `cnt`+1, and `sr` shifts toward the output end (left if `MSB_FIRST`, else right). Zeros fill the vacated end.
  - `D` = the output-end bit of `sr`.
  - `Busy`=1.
  - `Last`=1 while `cnt`==`WIDTH-1`.
- **Edge where `Last`=1:**
  - With accept: reload `sr` from the new `Din`, `cnt`=0, stay in SHIFT. The new first bit follows the old last bit on the next cycle with no gap.
  - Without accept: go to IDLE; `D`=0 on the next cycle.
- **Counter:** `cnt` never exceeds `WIDTH-1`; it wraps only through reload.
- **Reset:**
  - Applies asynchronously, at any time including mid-word.
  - State=IDLE, `sr`=0, `cnt`=0, so `D`=0, `Busy`=0, `Last`=0, `Ready`=1.
  - A partially sent word is discarded and is not resumed.
  - After deassertion, the first accept is possible at the next rising edge.

## Timing
- **Latency:** 0 cycles from the accepting edge to the first bit on `D`. Bit k (0-based transmit order) is valid on `D` between edges k and k+1 after acceptance.
- **Frame length:** exactly `WIDTH` cycles. Throughput is one word per `WIDTH` cycles when `Load` is held high.
- **Receiver sampling:** a receiver sampling `D` at rising edges captures bit k at edge k+1. The full word is present after edge `WIDTH` relative to acceptance.
- **Outputs:** `D`, `Busy`, `Last` are registered and change only on `Clk` edges or on `Rst` assertion. `Ready` is combinational from state and `Last`.
- **Reset values:** `D`=0, `Busy`=0, `Last`=0, `Ready`=1.

## Test plan
- **Reset:** assert `Rst` asynchronously between edges → `D`/`Busy`/`Last`=0 and `Ready`=1 immediately; `Load` held during reset is ignored.
- **Single word, MSB-first:** `WIDTH`=4, `Din`=4'b1011, one-cycle `Load` → `D` = 1,0,1,1 over 4 cycles, `Last` high only on the 4th bit, then `D`=0 and `Busy`=0. A 4-bit left-shift receiver on the same `Clk` holds 4'b1011 after 4 edges.
- **Back-to-back:** `Load` held high with `Din`=4'hA, then 4'h5 presented while `Last`=1 → 8 contiguous bits 1,0,1,0,0,1,0,1; `Busy` stays high for all 8 cycles; `Ready` is high only on cycles 0, 4 and 8.
- **Load while busy:** mid-frame `Load`=1 with `Din`=4'hF during transmission of 4'h0 → the transmission completes as 0,0,0,0 and 4'hF is never sent.
- **Reset mid-word:** assert `Rst` after 2 bits of 4'b1101 → `D`=0 at once; after release, 4'b0110 transmits cleanly as 0,1,1,0.
- **LSB-first:** `MSB_FIRST`=0, `WIDTH`=8, `Din`=8'h96 → `D` = 0,1,1,0,1,0,0,1, and `Last` is asserted on the 8th bit.
